// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB master port among NUM_REQ requesters.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT wait states with an err pulse.
module apb_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [NUM_REQ-1:0]        err,
    output logic [DATA_W-1:0]         rdata,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pready
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] err_q, err_d;
`endif

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0] elig;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic               end_xfer;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    // The owner's request is still high during its done cycle; mask it so it cannot re-win.
    assign elig = req & ~done_q;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!win_found && elig[IDX_W'((int'(ptr_q) + i) % NUM_REQ)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path can infer a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        end_xfer  = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d   = ST_SETUP;
                    ptr_d     = win_idx;
                    gnt_d     = NUM_REQ'(1) << win_idx;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = req_write[win_idx];
                    paddr_d   = addr_arr[win_idx];
                    pwdata_d  = wdata_arr[win_idx];
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ST_ACCESS: begin
                if (pready) begin
                    end_xfer = 1'b1;
                    if (!pwrite_q) rdata_d = prdata;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    end_xfer = 1'b1;
                    err_d    = gnt_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
                if (end_xfer) begin
                    state_d   = ST_IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    gnt_d     = '0;
                    done_d    = gnt_q;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                gnt_d     = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= IDX_W'(NUM_REQ - 1);
            gnt_q     <= '0;
            done_q    <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
`ifdef APB_ARB_TIMEOUT_EN
    assign err     = err_q;
`else
    assign err     = '0;
`endif

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level model (owner, age in cycles since grant, round-robin pointer).
module tb_apb_req_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;
`ifdef APB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                      pclk      = 1'b0;
    logic                      preset    = 1'b0;
    logic [NUM_REQ-1:0]        req       = '0;
    logic [NUM_REQ-1:0]        req_write = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr  = '0;
    logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
    logic [DATA_W-1:0]         prdata    = '0;
    logic                      pready    = 1'b1;
    logic [NUM_REQ-1:0]        gnt, done, err;
    logic [DATA_W-1:0]         rdata, pwdata;
    logic [ADDR_W-1:0]         paddr;
    logic                      psel, penable, pwrite;

    apb_req_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk(pclk), .preset(preset),
        .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    endtask

    // Transaction-level model: a transfer is "busy" from grant; age 0 is the setup cycle,
    // age >= 1 the access cycles; it ends on pready or when the access cycles reach TIMEOUT.
    bit                 m_busy  = 1'b0;
    int                 m_owner = 0;
    int                 m_age   = 0;
    int                 m_ptr   = NUM_REQ - 1;
    bit                 m_write = 1'b0;
    logic [NUM_REQ-1:0] m_done  = '0;
    logic [NUM_REQ-1:0] m_err   = '0;
    logic [ADDR_W-1:0]  m_addr  = '0;
    logic [DATA_W-1:0]  m_wdata = '0;
    logic [DATA_W-1:0]  m_rdata = '0;

    always @(posedge pclk or posedge preset) begin : model_step
        logic [NUM_REQ-1:0] elig;
        bit                 found;
        int                 c;
        if (preset) begin
            m_busy = 1'b0; m_owner = 0; m_age = 0; m_ptr = NUM_REQ - 1; m_write = 1'b0;
            m_done = '0; m_err = '0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else begin
            elig   = req & ~m_done;
            m_done = '0;
            m_err  = '0;
            if (m_busy) begin
                if (m_age >= 1 && pready) begin
                    m_busy = 1'b0;
                    m_done[m_owner] = 1'b1;
                    if (!m_write) m_rdata = prdata;
                end else if (TO_EN && m_age == TIMEOUT) begin
                    m_busy = 1'b0;
                    m_done[m_owner] = 1'b1;
                    m_err[m_owner]  = 1'b1;
                end else begin
                    m_age++;
                end
            end else begin
                found = 1'b0;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    c = (m_ptr + k) % NUM_REQ;
                    if (!found && elig[c]) begin
                        found   = 1'b1;
                        m_busy  = 1'b1;
                        m_age   = 0;
                        m_owner = c;
                        m_ptr   = c;
                        m_write = req_write[c];
                        m_addr  = req_addr[c*ADDR_W +: ADDR_W];
                        m_wdata = req_wdata[c*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    always @(negedge pclk) begin
        check("psel", psel, m_busy);
        check("penable", penable, m_busy && m_age >= 1);
        check("gnt", gnt, m_busy ? (1 << m_owner) : 0);
        check("done", done, m_done);
        check("err", err, m_err);
        check("rdata", rdata, m_rdata);
        check("paddr", paddr, m_addr);
        check("pwdata", pwdata, m_wdata);
        if (m_busy) check("pwrite", pwrite, m_write);
        check("gnt_onehot0", $onehot0(gnt), 1);
    end

    task automatic tick();
        @(negedge pclk);
    endtask

    task automatic do_reset();
        #2 preset = 1'b1;
        tick();
        tick();
        preset = 1'b0;
    endtask

    task automatic set_req(input int i, input bit wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        req_write[i]                 = wr;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_wdata[i*DATA_W +: DATA_W] = d;
        req[i]                       = 1'b1;
    endtask

    initial begin
        int grants[$];
        int done_cyc[$];
        int exp_g[5];
        int cyc;
        int n_done_seen;
        exp_g = '{1, 2, 4, 8, 1};

        // Reset: two cycles, then idle with no requests
        #1 preset = 1'b1;
        tick(); tick();
        preset = 1'b0;
        tick(); tick();
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_pwrite", pwrite, 0);

        // Single zero-wait write from requester 0
        set_req(0, 1'b1, 8'h03, 8'h21);
        pready = 1'b1;
        tick();
        check("wr_setup_psel", psel, 1);
        check("wr_setup_penable", penable, 0);
        check("wr_setup_gnt", gnt, 4'b0001);
        check("wr_setup_paddr", paddr, 8'h03);
        check("wr_setup_pwdata", pwdata, 8'h21);
        check("wr_setup_pwrite", pwrite, 1);
        tick();
        check("wr_access_penable", penable, 1);
        check("wr_access_paddr", paddr, 8'h03);
        check("wr_access_pwdata", pwdata, 8'h21);
        check("wr_access_done", done, 0);
        tick();
        check("wr_done", done, 4'b0001);
        check("wr_idle_psel", psel, 0);
        check("wr_rdata_kept", rdata, 0);
        req[0] = 1'b0;

        // Read from requester 1 with two wait states
        set_req(1, 1'b0, 8'h0E, 8'h00);
        pready = 1'b0;
        prdata = 8'h50;
        repeat (4) tick();
        check("rd_wait_done", done, 0);
        check("rd_wait_penable", penable, 1);
        check("rd_wait_gnt", gnt, 4'b0010);
        pready = 1'b1;
        tick();
        check("rd_done", done, 4'b0010);
        check("rd_rdata", rdata, 8'h50);
        check("rd_err", err, 0);
        req[1] = 1'b0;

        // Contention: all four hold their requests continuously
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 8'(8'h10 + i), 8'(8'hA0 + i));
        pready = 1'b1;
        cyc = 0;
        while ((grants.size() < 5 || done_cyc.size() < 4) && cyc < 40) begin
            tick();
            cyc++;
            if (psel && !penable) grants.push_back(int'(gnt));
            if (done != 0) done_cyc.push_back(cyc);
        end
        check("contention_bound", cyc < 40, 1);
        for (int k = 0; k < 5; k++)
            check($sformatf("grant_order_%0d", k), (k < grants.size()) ? grants[k] : -1, exp_g[k]);
        check("contention_first_done", (done_cyc.size() > 0) ? done_cyc[0] : -1, 3);
        for (int k = 1; k < 4; k++)
            check($sformatf("done_spacing_%0d", k),
                  (k < done_cyc.size()) ? done_cyc[k] - done_cyc[k-1] : -1, 3);
        req = '0;
        repeat (3) tick();

        // Long wait states: timeout abort when compiled in, otherwise indefinite wait
        do_reset();
        set_req(2, 1'b0, 8'h40, 8'h00);
        pready = 1'b1;
        prdata = 8'h5A;
        repeat (3) tick();
        check("to_prime_done", done, 4'b0100);
        check("to_prime_rdata", rdata, 8'h5A);
        req[2] = 1'b0;
        tick();
        set_req(2, 1'b0, 8'h41, 8'h00);
        pready = 1'b0;
        prdata = 8'hC3;
        repeat (16) tick();
        check("to_wait_done", done, 0);
        check("to_wait_psel", psel, 1);
`ifdef APB_ARB_TIMEOUT_EN
        tick();
        check("to_abort_done", done, 4'b0100);
        check("to_abort_err", err, 4'b0100);
        check("to_abort_rdata", rdata, 8'h5A);
        check("to_abort_psel", psel, 0);
`else
        repeat (4) tick();
        check("noto_still_waiting", psel, 1);
        check("noto_no_done", done, 0);
        pready = 1'b1;
        tick();
        check("noto_done", done, 4'b0100);
        check("noto_err", err, 0);
        check("noto_rdata", rdata, 8'hC3);
`endif
        req[2] = 1'b0;
        tick();

        // Reset pulse while requester 2 is in ACCESS
        do_reset();
        set_req(2, 1'b0, 8'h22, 8'h00);
        pready = 1'b0;
        tick(); tick();
        check("rma_pre_penable", penable, 1);
        check("rma_pre_gnt", gnt, 4'b0100);
        #2 preset = 1'b1;
        #1;
        check("rma_async_psel", psel, 0);
        check("rma_async_penable", penable, 0);
        check("rma_async_gnt", gnt, 0);
        set_req(0, 1'b1, 8'h11, 8'h77);
        tick();
        check("rma_no_done_in_reset", done, 0);
        preset = 1'b0;
        pready = 1'b1;
        tick();
        check("rma_next_gnt", gnt, 4'b0001);
        check("rma_no_done2", done, 0);
        tick(); tick();
        check("rma_done0", done, 4'b0001);

        // Randomized traffic; requesters drop on done and re-request at random
        n_done_seen = 0;
        for (int r = 0; r < 3000; r++) begin
            if (done != 0) n_done_seen++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && done[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            end
            pready = ($urandom_range(0, 3) != 0);
            prdata = 8'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2 preset = 1'b1;
                tick();
                preset = 1'b0;
            end else begin
                tick();
            end
        end
        check("random_progress", n_done_seen > 100, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
